// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Shared types and helpers for the universal shift register:
//                operation-select encoding and counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    // Operation select, encoded 0..7 in this exact order.
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        LOAD  = 3'd1,
        SHL   = 3'd2,
        SHR   = 3'd3,
        ROL   = 3'd4,
        ROR   = 3'd5,
        ASR   = 3'd6,
        CLEAR = 3'd7
    } shift_mode_t;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // True for the modes that move bits and therefore advance the shift count.
    function automatic logic is_shift_op(input shift_mode_t m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_shift_reg_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter from 0 to MAX that sticks at MAX. Synchronous
//                clear has priority over increment; asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import shift_reg_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      inc,
    output logic [cnt_width(MAX)-1:0] count
);

    localparam int                 CNT_W   = cnt_width(MAX);
    localparam logic [CNT_W-1:0]   C_MAX   = CNT_W'(MAX);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == C_MAX);

    // Count held at MAX once reached; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/param_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : param_shift_reg
//  Description : WIDTH-bit universal shift/storage register with parallel
//                load, logical shifts, rotates, arithmetic shift right,
//                clear and hold, plus a saturating shift counter and a
//                drained flag that rises after WIDTH shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  shift_mode_t                 mode,
    input  logic [WIDTH-1:0]            d,
    input  logic                        sin_l,
    input  logic                        sin_r,
    output logic [WIDTH-1:0]            q,
    output logic                        sout_l,
    output logic                        sout_r,
    output logic [cnt_width(WIDTH)-1:0] shift_cnt,
    output logic                        drained
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_cnt;

    // Next register value for each operation; HOLD and unknown keep q.
    always_comb begin
        w_q_next = r_q;
        case (mode)
            HOLD:    w_q_next = r_q;
            LOAD:    w_q_next = d;
            SHL:     w_q_next = {r_q[WIDTH-2:0], sin_r};
            SHR:     w_q_next = {sin_l, r_q[WIDTH-1:1]};
            ROL:     w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            ROR:     w_q_next = {r_q[0], r_q[WIDTH-1:1]};
            ASR:     w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            CLEAR:   w_q_next = '0;
            default: w_q_next = r_q;
        endcase
    end

    // Register contents update only on enabled edges; reset is immediate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= w_q_next;
        end
    end

    // LOAD and CLEAR restart the shift count; bit-moving modes advance it.
    assign w_cnt_clr = en && ((mode == LOAD) || (mode == CLEAR));
    assign w_cnt_inc = en && is_shift_op(mode);

    sat_counter #(
        .MAX   (WIDTH)
    ) u_shift_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_cnt_inc),
        .count (w_cnt)
    );

    assign q         = r_q;
    assign sout_l    = r_q[WIDTH-1];
    assign sout_r    = r_q[0];
    assign shift_cnt = w_cnt;
    assign drained   = (w_cnt == C_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_param_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_shift_reg
//  Description : Self-checking bench for param_shift_reg (WIDTH=8) using an
//                arithmetic reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_shift_reg;
    import shift_reg_pkg::*;

    localparam int W  = 8;
    localparam int M  = 1 << W;       // modulus for W-bit arithmetic
    localparam int HB = 1 << (W - 1); // weight of the MSB

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    shift_mode_t       mode;
    logic [W-1:0]      d;
    logic              sin_l;
    logic              sin_r;
    logic [W-1:0]      q;
    logic              sout_l;
    logic              sout_r;
    logic [cnt_width(W)-1:0] shift_cnt;
    logic              drained;

    int checks   = 0;
    int failures = 0;

    // Reference model: register value and shift count as plain integers.
    int q_m   = 0;
    int cnt_m = 0;

    param_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .drained   (drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update, written as integer arithmetic on the register value.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_m   <= 0;
            cnt_m <= 0;
        end else if (en) begin
            case (mode)
                LOAD:  begin q_m <= int'(d); cnt_m <= 0; end
                CLEAR: begin q_m <= 0;       cnt_m <= 0; end
                SHL:   q_m <= (q_m * 2 + int'(sin_r)) % M;
                SHR:   q_m <= q_m / 2 + int'(sin_l) * HB;
                ROL:   q_m <= (q_m * 2) % M + q_m / HB;
                ROR:   q_m <= q_m / 2 + (q_m % 2) * HB;
                ASR:   q_m <= q_m / 2 + ((q_m >= HB) ? HB : 0);
                default: q_m <= q_m;
            endcase
            if (mode inside {SHL, SHR, ROL, ROR, ASR})
                cnt_m <= (cnt_m < W) ? cnt_m + 1 : W;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_q",       32'(q),         32'(q_m));
        chk("cyc_sout_l",  32'(sout_l),    32'(q_m / HB));
        chk("cyc_sout_r",  32'(sout_r),    32'(q_m % 2));
        chk("cyc_cnt",     32'(shift_cnt), 32'(cnt_m));
        chk("cyc_drained", 32'(drained),   32'(cnt_m == W));
    end

    task automatic op(input logic e, input shift_mode_t m, input logic [W-1:0] dv,
                      input logic sl, input logic sr);
        en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0; mode = HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;
        #2;
        chk("rst_q",       32'(q),         32'h00);
        chk("rst_cnt",     32'(shift_cnt), 32'd0);
        chk("rst_drained", 32'(drained),   32'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // Reset asserted between edges in the middle of a shift sequence.
        op(1'b1, LOAD, 8'hFF, 1'b0, 1'b0);
        op(1'b1, SHL,  8'h00, 1'b0, 1'b1);
        op(1'b1, SHL,  8'h00, 1'b0, 1'b1);
        chk("pre_rst_cnt", 32'(shift_cnt), 32'd2);
        #3 reset = 1'b1;
        #1;
        chk("midrst_q",       32'(q),         32'h00);
        chk("midrst_cnt",     32'(shift_cnt), 32'd0);
        chk("midrst_drained", 32'(drained),   32'd0);
        @(posedge clk); #1;
        en = 1'b0;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_q", 32'(q), 32'h00);

        // LOAD then three SHL with sin_r=1.
        op(1'b1, LOAD, 8'hA5, 1'b0, 1'b0);
        op(1'b1, SHL, 8'h00, 1'b0, 1'b1); chk("shl1", 32'(q), 32'h4B);
        op(1'b1, SHL, 8'h00, 1'b0, 1'b1); chk("shl2", 32'(q), 32'h97);
        op(1'b1, SHL, 8'h00, 1'b0, 1'b1); chk("shl3", 32'(q), 32'h2F);
        chk("shl_sout_l", 32'(sout_l),    32'd0);
        chk("shl_cnt",    32'(shift_cnt), 32'd3);

        // Rotates.
        op(1'b1, LOAD, 8'h81, 1'b0, 1'b0);
        op(1'b1, ROR, 8'h00, 1'b1, 1'b1); chk("ror",  32'(q), 32'hC0);
        op(1'b1, ROL, 8'h00, 1'b0, 1'b0); chk("rol1", 32'(q), 32'h81);
        op(1'b1, ROL, 8'h00, 1'b0, 1'b0); chk("rol2", 32'(q), 32'h03);
        chk("rot_cnt", 32'(shift_cnt), 32'd3);

        // Arithmetic and logical shift right.
        op(1'b1, LOAD, 8'h80, 1'b0, 1'b0);
        op(1'b1, ASR, 8'h00, 1'b0, 1'b0); chk("asr1", 32'(q), 32'hC0);
        op(1'b1, ASR, 8'h00, 1'b0, 1'b0); chk("asr2", 32'(q), 32'hE0);
        op(1'b1, ASR, 8'h00, 1'b0, 1'b0); chk("asr3", 32'(q), 32'hF0);
        op(1'b1, LOAD, 8'h80, 1'b0, 1'b0);
        op(1'b1, SHR, 8'h00, 1'b0, 1'b0); chk("shr0", 32'(q), 32'h40);
        op(1'b1, LOAD, 8'h80, 1'b0, 1'b0);
        op(1'b1, SHR, 8'h00, 1'b1, 1'b0); chk("shr1", 32'(q), 32'hC0);

        // Saturation of the shift count and drained flag.
        op(1'b1, LOAD, 8'h01, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            op(1'b1, SHL, 8'h00, 1'b0, 1'b0);
            if (i == 7) chk("drain_before", 32'(drained), 32'd0);
            if (i == 8) begin
                chk("drain_at8", 32'(drained), 32'd1);
                chk("q_at8",     32'(q),       32'h00);
            end
        end
        chk("sat_cnt", 32'(shift_cnt), 32'd8);
        op(1'b1, SHL, 8'h00, 1'b0, 1'b1); chk("sat_shl_q", 32'(q), 32'h01);
        op(1'b1, ROR, 8'h00, 1'b0, 1'b0); chk("sat_ror_q", 32'(q), 32'h80);
        chk("sat_ror_cnt", 32'(shift_cnt), 32'd8);
        op(1'b1, LOAD, 8'h55, 1'b0, 1'b0);
        chk("reload_cnt",     32'(shift_cnt), 32'd0);
        chk("reload_drained", 32'(drained),   32'd0);

        // HOLD with en=1 keeps everything.
        op(1'b1, HOLD, 8'hAA, 1'b1, 1'b1);
        chk("hold_q", 32'(q), 32'h55);

        // Enable low blocks a pending LOAD; then CLEAR.
        op(1'b1, LOAD, 8'h1E, 1'b0, 1'b0);
        op(1'b1, SHL, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) op(1'b0, LOAD, 8'hFF, 1'b1, 1'b1);
        chk("en0_q",   32'(q),         32'h3C);
        chk("en0_cnt", 32'(shift_cnt), 32'd1);
        op(1'b1, CLEAR, 8'hFF, 1'b0, 1'b0);
        chk("clear_q",   32'(q),         32'h00);
        chk("clear_cnt", 32'(shift_cnt), 32'd0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised WIDTH-bit universal shift/storage register; edge-triggered successor to the single-bit level-sensitive D latch.
- Provides parallel load, logical shifts, rotates, arithmetic shift, clear and hold under a mode select.
- Adds a saturating shift counter and a drained flag.
- Used as the generic storage and serialiser element in the team's datapath exercises and serial-link benches.

Parameters:
- WIDTH, 8: register width in bits; legal range WIDTH >= 2.
- RESET_VAL, 0: value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when 0, all state holds.
- mode  input  3  operation select, encoded as shift_mode_t.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB on SHR.
- sin_r  input  1  serial input entering at the LSB on SHL.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- shift_cnt  output  $clog2(WIDTH+1)  shift operations since the last LOAD/CLEAR/reset; saturating.
- drained  output  1  high when shift_cnt == WIDTH.

Behaviour:
- Reset:
  - reset=1 forces q=RESET_VAL and shift_cnt=0 immediately, with no clock edge needed; drained=0.
  - Reset dominates en and mode.
  - Assertion mid-operation discards the operation in progress.
  - On deassertion, the first update is the next rising clk edge with reset=0.
- en=0 at a rising edge: q and shift_cnt hold, regardless of mode or d.
- en=1 at a rising edge, by mode:
  - 0 HOLD: no change to q or shift_cnt.
  - 1 LOAD: q<=d; shift_cnt<=0.
  - 2 SHL: q<={q[W-2:0],sin_r}.
  - 3 SHR: q<={sin_l,q[W-1:1]}.
  - 4 ROL: q<={q[W-2:0],q[W-1]}.
  - 5 ROR: q<={q[0],q[W-1:1]}.
  - 6 ASR: q<={q[W-1],q[W-1:1]}; sign bit replicated, sin_l ignored.
  - 7 CLEAR: q<=0 (not RESET_VAL); shift_cnt<=0.
- shift_cnt:
  - Increments by 1 on each enabled mode 2..6.
  - Saturates at WIDTH and never wraps.
  - LOAD and CLEAR win over increment.
- Latency:
  - q and shift_cnt: 1 cycle from sampling edge.
  - sout_l, sout_r, drained: combinational from registered state; no extra cycle.
- Boundaries:
  - Rotate after saturation still rotates q; shift_cnt stays WIDTH.
  - Mode changes between edges have no effect until the next edge.
  - Inputs are sampled only at rising edges; no level-sensitive transparency.
- Width rules:
  - All operations are exactly WIDTH bits; no carry out beyond sout_l/sout_r.
  - RESET_VAL is truncated/zero-extended to WIDTH.

Decomposition:
- Package shift_reg_pkg:
  - typedef enum logic [2:0] shift_mode_t {HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, CLEAR}, encoded 0..7.
  - Helper function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- Sub-module sat_counter (parameter MAX, inputs clk, reset, clr, inc; output count) implements shift_cnt.
- param_shift_reg instantiates sat_counter with MAX=WIDTH.

Test Plan:
- WIDTH=8. Assert reset mid-way through a SHL sequence, between clock edges -> q=0x00 and shift_cnt=0 at once; drained=0; after release q holds 0x00 until the next enabled op.
- LOAD d=0xA5, then 3x SHL with sin_r=1 -> q=0x4B, 0x97, 0x2F on successive edges; sout_l=0 at end; shift_cnt=3.
- LOAD 0x81, ROR -> 0xC0; ROL, ROL -> 0x81, 0x03; shift_cnt=3.
- LOAD 0x80, 3x ASR -> 0xC0, 0xE0, 0xF0. LOAD 0x80, SHR with sin_l=0 -> 0x40; with sin_l=1 -> 0xC0.
- LOAD 0x01, then 10x SHL with sin_r=0 -> drained=1 from the 8th shift, q=0x00; shift_cnt stays 8 after shifts 9 and 10; LOAD 0x55 -> shift_cnt=0, drained=0.
- q=0x3C, en=0, mode=LOAD, d=0xFF for 4 edges -> q stays 0x3C, shift_cnt unchanged. Then en=1, mode=CLEAR -> q=0x00, shift_cnt=0.
